// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// the counter reset value, and small helpers used across the slice.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,  // strongly not-taken
    CNT_WNT = 2'b01,  // weakly not-taken
    CNT_WT  = 2'b10,  // weakly taken
    CNT_ST  = 2'b11   // strongly taken
  } bp_cnt_e;

  localparam logic [1:0]  CNT_RESET = CNT_WNT;
  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  // Increment a 32-bit event counter, holding at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == COUNT_MAX) ? val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Prediction/update bus of the branch predictor. The master side is the
// pipeline (fetch + resolution); the slave side is the predictor itself.
interface branch_predictor_if #(parameter int IDX_W = 6);

  logic [31:0]      pred_pc;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_pred;
  logic             mispredict;
  logic [31:0]      br_count;
  logic [31:0]      mp_count;

  modport master (
    output pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
    input  pred_taken, pred_idx, mispredict, br_count, mp_count
  );

  modport slave (
    input  pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
    output pred_taken, pred_idx, mispredict, br_count, mp_count
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic of one 2-bit saturating counter: count up on taken,
// down on not-taken, holding at the strong ends.
module bp_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] next
);

  // Saturating step toward the observed outcome.
  always_comb begin
    next = cnt;
    case (cnt)
      CNT_SNT: next = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: next = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  next = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  next = taken ? CNT_ST  : CNT_WT;
      default: next = CNT_RESET;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: table of 2-bit saturating counters indexed by
// PC[IDX_W+1:2], read combinationally at fetch and updated at resolution.
// Optional macro BP_GSHARE_EN XORs the index with a non-speculative
// global history register updated only by resolved branches.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_ENTRIES = 64
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] pred_idx_s;
  logic [1:0]       upd_cnt_s;
  logic [1:0]       upd_next_s;
  logic             mismatch_s;
  logic             mispredict_q, mispredict_d;
  logic [31:0]      br_count_q, br_count_d;
  logic [31:0]      mp_count_q, mp_count_d;
  logic             pc_unused_s;

  // PC bits outside the index field do not participate in prediction.
  assign pc_unused_s = ^{bus.pred_pc[31:IDX_W+2], bus.pred_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  // Fetch index hashes the PC with resolved-branch history.
  always_comb begin
    pred_idx_s = bus.pred_pc[IDX_W+1:2] ^ ghr_q;
  end

  // History shifts in each resolved outcome; otherwise it holds.
  always_comb begin
    if (bus.upd_valid) begin
      ghr_d = {ghr_q[IDX_W-2:0], bus.upd_taken};
    end else begin
      ghr_d = ghr_q;
    end
  end

  // History register, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  // Fetch index is taken straight from the word-aligned PC.
  always_comb begin
    pred_idx_s = bus.pred_pc[IDX_W+1:2];
  end
`endif

  // Prediction reads the stored counter; an update in the same cycle is not
  // forwarded, so a matching index sees the pre-update value.
  assign bus.pred_idx   = pred_idx_s;
  assign bus.pred_taken = bht_q[pred_idx_s][1];

  assign upd_cnt_s = bht_q[bus.upd_idx];

  bp_sat_counter2 u_sat (
    .cnt   (upd_cnt_s),
    .taken (bus.upd_taken),
    .next  (upd_next_s)
  );

  // Statistics and mispredict flag next-state; outcome bits are don't-care
  // unless an update is present.
  always_comb begin
    mismatch_s   = bus.upd_valid & (bus.upd_taken != bus.upd_pred);
    mispredict_d = mismatch_s;
    if (bus.upd_valid) begin
      br_count_d = sat_inc32(br_count_q);
    end else begin
      br_count_d = br_count_q;
    end
    if (mismatch_s) begin
      mp_count_d = sat_inc32(mp_count_q);
    end else begin
      mp_count_d = mp_count_q;
    end
  end

  // Counter table: single write port; reset wins over a concurrent update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CNT_RESET;
      end
    end else if (bus.upd_valid) begin
      bht_q[bus.upd_idx] <= upd_next_s;
    end
  end

  // Registered mispredict flag and event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_q <= 1'b0;
      br_count_q   <= 32'd0;
      mp_count_q   <= 32'd0;
    end else begin
      mispredict_q <= mispredict_d;
      br_count_q   <= br_count_d;
      mp_count_q   <= mp_count_d;
    end
  end

  assign bus.mispredict = mispredict_q;
  assign bus.br_count   = br_count_q;
  assign bus.mp_count   = mp_count_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 64, meaning number of 2-bit counters (power of 2, 4..1024); IDX_W = log2(BHT_ENTRIES).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pred_pc  input  32  fetch-stage PC to predict.
REQ-005 SHALL have port pred_taken  output  1  prediction for pred_pc (combinational table read).
REQ-006 SHALL have port pred_idx  output  IDX_W  table index used for pred_pc, carried down the pipeline.
REQ-007 SHALL have port upd_valid  input  1  resolved conditional branch present this cycle.
REQ-008 SHALL have port upd_idx  input  IDX_W  index returned with the resolved branch.
REQ-009 SHALL have port upd_taken  input  1  actual outcome from branch resolution.
REQ-010 SHALL have port upd_pred  input  1  prediction originally made for that branch.
REQ-011 SHALL have port mispredict  output  1  registered; high one cycle after a mismatched update.
REQ-012 SHALL have port br_count  output  32  resolved-branch count.
REQ-013 SHALL have port mp_count  output  32  misprediction count.

Function
REQ-014 SHALL hold BHT_ENTRIES 2-bit saturating counters; pred_taken = counter[pred_idx][1].
REQ-015 SHALL compute pred_idx = pred_pc[IDX_W+1:2] when the hashing feature is absent.
REQ-016 SHALL, on a clock edge with upd_valid=1 and upd_taken=1, increment counter[upd_idx], saturating at 2'b11.
REQ-017 SHALL, on a clock edge with upd_valid=1 and upd_taken=0, decrement counter[upd_idx], saturating at 2'b00.
REQ-018 SHALL leave every counter unchanged when upd_valid=0.
REQ-019 SHALL, when pred_idx equals upd_idx in the same cycle, drive pred_taken from the pre-update value (no bypass).
REQ-020 SHALL register mispredict <= upd_valid & (upd_taken != upd_pred); latency is exactly one cycle.
REQ-021 SHALL increment br_count on each upd_valid cycle, and mp_count on each mismatched upd_valid cycle; both saturate at 32'hFFFF_FFFF.
REQ-022 SHALL ignore upd_taken and upd_pred when upd_valid=0.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, set all counters to 2'b01 (weakly not-taken), mispredict to 0, br_count and mp_count to 0, and the history register to 0.
REQ-024 SHALL give rst priority over a simultaneous upd_valid; that update is discarded.
REQ-025 SHALL drive pred_taken=0 for every index in the cycle after reset.

Configuration
REQ-026 SHALL support macro BP_GSHARE_EN.
- Defined: adds an IDX_W-bit global history register ghr.
  - pred_idx = pred_pc[IDX_W+1:2] XOR ghr.
  - On upd_valid, ghr <= {ghr[IDX_W-2:0], upd_taken}.
  - History is updated at resolution only; it is non-speculative.
- Undefined: no ghr is instantiated, and the indexing of REQ-015 applies.

Structure
REQ-027 SHALL take the counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the reset value from the shared defines file.
REQ-028 SHALL place the saturating 2-bit counter update in sub-module bp_sat_counter2, inputs cnt and taken, output next.
REQ-029 SHALL keep the table as a flat register array with one write port and one combinational read port.

Verification
REQ-030 SHALL: after reset, pred_pc=0x100 -> pred_taken=0, pred_idx=0 (BHT_ENTRIES=64, no GSHARE).
REQ-031 SHALL: two updates idx=5, taken=1 -> counter 01->10->11; pred_pc=0x14 gives pred_taken=1; a third taken update leaves it at 11.
REQ-032 SHALL: upd_valid=1, upd_taken=1, upd_pred=0 -> mispredict=1 exactly the next cycle, mp_count=1, br_count=1.
REQ-033 SHALL: same-cycle pred and upd on idx 7 with counter=01 and taken=1 -> pred_taken=0 that cycle, 1 the next cycle.
REQ-034 SHALL: rst asserted with upd_valid=1 -> counters stay 01, br_count=0, mispredict=0.
REQ-035 SHALL: with BP_GSHARE_EN, taken updates T,T,N -> ghr=3'b110 in the low bits; pred_pc=0x0 gives pred_idx=6'b000110.
